// File: rtl/key_filter.sv
// Push-button front end: 2-stage synchroniser plus counter-based debounce FSM.
// Produces press/release/long-press pulses, a debounced level and a wrapping press count.
`timescale 1ns/1ps
module key_filter #(
    parameter logic [19:0] CNT_MAX  = 20'd999_999,
    parameter logic [25:0] LONG_MAX = 26'd49_999_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_in,
    output logic       key_press,
    output logic       key_release,
    output logic       key_long,
    output logic       key_state,
    output logic [3:0] press_cnt
);

    localparam int unsigned CNT_W  = 20;
    localparam int unsigned HOLD_W = 26;
    localparam int unsigned PCNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_FILT,
        DOWN,
        RELEASE_FILT
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          sync_q;
    logic                key_sync;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_cnt_nxt;
    logic                long_done;
    logic                long_done_nxt;
    logic                key_press_nxt;
    logic                key_release_nxt;
    logic                key_long_nxt;
    logic                key_state_nxt;
    logic [PCNT_W-1:0]   press_cnt_nxt;

    assign key_sync = sync_q[1];

    // Raw key is asynchronous; idle level is released (1).
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_in};
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            hold_cnt    <= '0;
            long_done   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            key_state   <= 1'b0;
            press_cnt   <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            hold_cnt    <= hold_cnt_nxt;
            long_done   <= long_done_nxt;
            key_press   <= key_press_nxt;
            key_release <= key_release_nxt;
            key_long    <= key_long_nxt;
            key_state   <= key_state_nxt;
            press_cnt   <= press_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        hold_cnt_nxt    = hold_cnt;
        long_done_nxt   = long_done;
        key_press_nxt   = 1'b0;
        key_release_nxt = 1'b0;
        key_long_nxt    = 1'b0;
        press_cnt_nxt   = press_cnt;

        case (state)
            IDLE: begin
                if (!key_sync) begin
                    state_nxt = PRESS_FILT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_FILT: begin
                if (key_sync) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt     = DOWN;
                    cnt_nxt       = '0;
                    key_press_nxt = 1'b1;
                    press_cnt_nxt = press_cnt + PCNT_W'(1);
                    hold_cnt_nxt  = '0;
                    long_done_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DOWN: begin
                // Hold counter stops at the terminal count so key_long fires once per press.
                if (!long_done) begin
                    if (hold_cnt == LONG_MAX) begin
                        key_long_nxt  = 1'b1;
                        long_done_nxt = 1'b1;
                    end else begin
                        hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                    end
                end
                if (key_sync) begin
                    state_nxt = RELEASE_FILT;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_FILT: begin
                // A bounce back to pressed resumes the paused hold count.
                if (!key_sync) begin
                    state_nxt = DOWN;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt       = IDLE;
                    cnt_nxt         = '0;
                    key_release_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        key_state_nxt = (state_nxt == DOWN) || (state_nxt == RELEASE_FILT);
    end

endmodule

// File: tb/tb_key_filter.sv
// Bench for key_filter: run-length reference model of the debouncer, directed scenarios
// with hand-computed edge numbers, then randomized press/bounce traffic with sporadic resets.
`timescale 1ns/1ps
module tb_key_filter;

    localparam logic [19:0] CNT_MAX    = 20'd9;
    localparam logic [25:0] LONG_MAX   = 26'd49;
    localparam int          FILT_RUN   = int'(CNT_MAX) + 2;  // consecutive synced samples to accept a change
    localparam int          LONG_EDGES = int'(LONG_MAX) + 1; // stable-pressed cycles before key_long

    logic       sys_clk;
    logic       sys_rst_n;
    logic       key_in;
    logic       key_press;
    logic       key_release;
    logic       key_long;
    logic       key_state;
    logic [3:0] press_cnt;

    key_filter #(
        .CNT_MAX  (CNT_MAX),
        .LONG_MAX (LONG_MAX)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .key_in      (key_in),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long),
        .key_state   (key_state),
        .press_cnt   (press_cnt)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    int n_vec;
    int n_err;
    int edge_n;
    int n_press;
    int n_rel;
    int n_long;
    int press_edge;
    int rel_edge;
    int long_edge;

    // Reference model: debounced level flips after FILT_RUN consecutive synced samples that disagree.
    logic [1:0] m_hist;
    logic       m_deb;
    int         m_run;
    int         m_down;
    logic       m_press;
    logic       m_rel;
    logic       m_long;
    logic [3:0] m_pcnt;

    task automatic model_reset();
        m_hist  = 2'b11;
        m_deb   = 1'b0;
        m_run   = 0;
        m_down  = 0;
        m_press = 1'b0;
        m_rel   = 1'b0;
        m_long  = 1'b0;
        m_pcnt  = 4'd0;
    endtask

    task automatic model_step();
        logic ks;
        ks      = m_hist[1];
        m_hist  = {m_hist[0], key_in};
        m_press = 1'b0;
        m_rel   = 1'b0;
        m_long  = 1'b0;
        if (m_deb && m_run == 0) begin
            m_down++;
            if (m_down == LONG_EDGES) m_long = 1'b1;
        end
        if ((!ks) != m_deb) begin
            m_run++;
            if (m_run == FILT_RUN) begin
                m_deb = !m_deb;
                m_run = 0;
                if (m_deb) begin
                    m_press = 1'b1;
                    m_pcnt  = m_pcnt + 4'd1;
                    m_down  = 0;
                end else begin
                    m_rel = 1'b1;
                end
            end
        end else begin
            m_run = 0;
        end
    endtask

    task automatic check1(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        int pulses;
        check1("key_press", int'(key_press), int'(m_press));
        check1("key_release", int'(key_release), int'(m_rel));
        check1("key_long", int'(key_long), int'(m_long));
        check1("key_state", int'(key_state), int'(m_deb));
        check1("press_cnt", int'(press_cnt), int'(m_pcnt));
        pulses = int'(key_press) + int'(key_release) + int'(key_long);
        check1("pulse_exclusive", (pulses > 1) ? 1 : 0, 0);
    endtask

    // One clock: drive at the falling edge, model at the rising edge, compare at the next falling edge.
    task automatic step(input logic k);
        key_in = k;
        @(posedge sys_clk);
        model_step();
        @(negedge sys_clk);
        edge_n++;
        compare_all();
        if (key_press === 1'b1) begin
            n_press++;
            press_edge = edge_n;
        end
        if (key_release === 1'b1) begin
            n_rel++;
            rel_edge = edge_n;
        end
        if (key_long === 1'b1) begin
            n_long++;
            long_edge = edge_n;
        end
    endtask

    task automatic hold(input logic k, input int n);
        repeat (n) step(k);
    endtask

    // Called at a falling edge; reset is released at a falling edge so the next rising edge is edge 1.
    task automatic apply_reset(input logic k, input int n);
        key_in    = k;
        sys_rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        repeat (n) begin
            @(negedge sys_clk);
            compare_all();
        end
        sys_rst_n = 1'b1;
        edge_n    = 0;
    endtask

    int base_p;
    int base_r;
    int base_l;
    logic lvl;
    int len;

    initial begin
        n_vec      = 0;
        n_err      = 0;
        edge_n     = 0;
        n_press    = 0;
        n_rel      = 0;
        n_long     = 0;
        press_edge = -1;
        rel_edge   = -1;
        long_edge  = -1;
        key_in     = 1'b1;
        sys_rst_n  = 1'b0;
        model_reset();
        @(negedge sys_clk);
        apply_reset(1'b1, 3);

        // Idle after reset
        hold(1'b1, 100);
        check1("idle_press_cnt", int'(press_cnt), 0);
        check1("idle_pulses", n_press + n_rel + n_long, 0);

        // Clean long press and release
        edge_n = 0;
        hold(1'b0, 200);
        check1("press_edge", press_edge, 13);
        check1("long_edge", long_edge, 63);
        check1("long_once", n_long, 1);
        check1("press_cnt_first", int'(press_cnt), 1);
        check1("state_held", int'(key_state), 1);
        edge_n = 0;
        hold(1'b1, 40);
        check1("release_edge", rel_edge, 13);
        check1("release_once", n_rel, 1);
        check1("state_released", int'(key_state), 0);

        // Press bounce rejected, then a clean press
        base_p = n_press;
        hold(1'b0, 5);
        hold(1'b1, 3);
        hold(1'b0, 4);
        hold(1'b1, 30);
        check1("bounce_no_press", n_press - base_p, 0);
        check1("bounce_press_cnt", int'(press_cnt), 1);
        hold(1'b0, 30);
        hold(1'b1, 30);
        check1("clean_press_once", n_press - base_p, 1);
        check1("clean_press_cnt", int'(press_cnt), 2);

        // Release bounce while down: hold count pauses and resumes
        base_r = n_rel;
        base_l = n_long;
        edge_n = 0;
        hold(1'b0, 30);
        hold(1'b1, 6);
        check1("rel_bounce_no_release", n_rel - base_r, 0);
        check1("rel_bounce_state", int'(key_state), 1);
        hold(1'b0, 60);
        check1("resumed_long_edge", long_edge, 69);
        check1("resumed_long_once", n_long - base_l, 1);
        hold(1'b1, 30);
        check1("rel_after_bounce", n_rel - base_r, 1);

        // Counter wrap over 17 short presses
        apply_reset(1'b1, 3);
        base_p = n_press;
        base_r = n_rel;
        base_l = n_long;
        for (int i = 1; i <= 17; i++) begin
            hold(1'b0, 20);
            check1("press_cnt_seq", int'(press_cnt), i % 16);
            hold(1'b1, 20);
        end
        check1("wrap_presses", n_press - base_p, 17);
        check1("wrap_releases", n_rel - base_r, 17);
        check1("wrap_no_long", n_long - base_l, 0);

        // Reset mid-down with the key still held
        hold(1'b0, 20);
        apply_reset(1'b0, 5);
        check1("rst_state", int'(key_state), 0);
        check1("rst_press_cnt", int'(press_cnt), 0);
        base_p = n_press;
        hold(1'b0, 20);
        check1("requal_press_edge", press_edge, 13);
        check1("requal_press_once", n_press - base_p, 1);
        check1("requal_press_cnt", int'(press_cnt), 1);
        hold(1'b1, 30);

        // Randomized traffic: short bounces, qualified presses, long holds, sporadic resets
        for (int s = 0; s < 400; s++) begin
            if ($urandom_range(0, 49) == 0) apply_reset(key_in, int'($urandom_range(1, 4)));
            lvl = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 12)) : int'($urandom_range(8, 70));
            hold(lvl, len);
        end
        hold(1'b1, 30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
